// File: rtl/counterc_312_arb.sv
// counterc_312_arb: NREQ requesters share one counter datapath under a
// round-robin arbiter. Each granted operand is reduced to
//   popcount(c0) + 2*c1 + 4*popcount(c2)
// and flows through a LAT-deep stallable pipeline to a valid/ready output.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   req_valid      per-requester operand valid
//   req_ready      per-requester grant, combinational in the grant cycle
//   req_c0         weight-1 bits, requester i at [2i+1:2i]
//   req_c1         weight-2 bit,  requester i at [i]
//   req_c2         weight-4 bits, requester i at [3i+2:3i]
//   out_valid      result valid
//   out_ready      downstream accepts the result
//   out_id         requester index that owns the result
//   out_sum        compressed count, 0..16
//   stat_sel       grant counter select
//   stat_cnt       registered grant count of requester stat_sel
//
// Optional feature: define COUNTERC_ARB_STATS_EN to build one saturating
// 16-bit grant counter per requester; otherwise stat_cnt is tied to zero.
module counterc_312_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [2*NREQ-1:0]         req_c0,
  input  logic [NREQ-1:0]           req_c1,
  input  logic [3*NREQ-1:0]         req_c2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(NREQ)-1:0]   out_id,
  output logic [4:0]                out_sum,
  input  logic [$clog2(NREQ)-1:0]   stat_sel,
  output logic [15:0]               stat_cnt
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned SW  = 5;
  localparam int unsigned CW  = 16;

  logic [IDW-1:0] ptr_q;
  logic           stall_c;
  logic           grant_vld_c;
  logic [IDW-1:0] grant_id_c;
  logic           hi_vld_c;
  logic [IDW-1:0] hi_id_c;
  logic           lo_vld_c;
  logic [IDW-1:0] lo_id_c;
  logic [1:0]     op_c0_c;
  logic           op_c1_c;
  logic [2:0]     op_c2_c;
  logic [SW-1:0]  sum_c;

  logic           st_vld_q [LAT];
  logic [IDW-1:0] st_id_q  [LAT];
  logic [SW-1:0]  st_sum_q [LAT];

  // Output stage is masked by rst so nothing escapes while reset is held.
  assign out_valid = st_vld_q[LAT-1] & ~rst;
  assign out_id    = rst ? '0 : st_id_q[LAT-1];
  assign out_sum   = rst ? '0 : st_sum_q[LAT-1];
  assign stall_c   = out_valid & ~out_ready;

  // Round-robin pick: lowest valid index >= ptr, else lowest valid overall (wrap).
  always_comb begin
    hi_vld_c = 1'b0;
    hi_id_c  = '0;
    lo_vld_c = 1'b0;
    lo_id_c  = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_vld_c = 1'b1;
        lo_id_c  = IDW'(i);
        if (IDW'(i) >= ptr_q) begin
          hi_vld_c = 1'b1;
          hi_id_c  = IDW'(i);
        end
      end
    end
    grant_id_c  = hi_vld_c ? hi_id_c : lo_id_c;
    grant_vld_c = lo_vld_c & ~stall_c & ~rst;
  end

  // One-hot accept for the granted requester.
  always_comb begin
    req_ready = '0;
    if (grant_vld_c) begin
      req_ready[grant_id_c] = 1'b1;
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    op_c0_c = '0;
    op_c1_c = 1'b0;
    op_c2_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_id_c) begin
        op_c0_c = req_c0[2*i +: 2];
        op_c1_c = req_c1[i];
        op_c2_c = req_c2[3*i +: 3];
      end
    end
  end

  // Weighted count; max 2 + 2 + 12 = 16 fits in 5 bits.
  assign sum_c = SW'(op_c0_c[0]) + SW'(op_c0_c[1]) + {3'b000, op_c1_c, 1'b0}
               + {2'b00, op_c2_c[0], 2'b00} + {2'b00, op_c2_c[1], 2'b00}
               + {2'b00, op_c2_c[2], 2'b00};

  // Round-robin pointer moves past the last winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (grant_vld_c) begin
      ptr_q <= (grant_id_c == IDW'(NREQ - 1)) ? '0 : grant_id_c + IDW'(1);
    end
  end

  // Pipeline: global hold on stall, bubbles carried as st_vld_q = 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        st_vld_q[i] <= 1'b0;
        st_id_q[i]  <= '0;
        st_sum_q[i] <= '0;
      end
    end else if (!stall_c) begin
      st_vld_q[0] <= grant_vld_c;
      st_id_q[0]  <= grant_id_c;
      st_sum_q[0] <= sum_c;
      for (int unsigned i = 1; i < LAT; i++) begin
        st_vld_q[i] <= st_vld_q[i-1];
        st_id_q[i]  <= st_id_q[i-1];
        st_sum_q[i] <= st_sum_q[i-1];
      end
    end
  end

`ifdef COUNTERC_ARB_STATS_EN
  logic [CW-1:0] cnt_q [NREQ];

  // Saturating per-requester grant counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (grant_vld_c && (cnt_q[grant_id_c] != {CW{1'b1}})) begin
      cnt_q[grant_id_c] <= cnt_q[grant_id_c] + CW'(1);
    end
  end

  // Registered read port; out-of-range selects read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt <= '0;
    end else if (32'(stat_sel) < NREQ) begin
      stat_cnt <= cnt_q[stat_sel];
    end else begin
      stat_cnt <= '0;
    end
  end
`else
  logic unused_stat_sel;

  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_counterc_312_arb.sv
// Directed bench for counterc_312_arb (NREQ=4, LAT=2).
// Operands are fixed per requester so each owner has a distinct sum:
//   req0 c0=00 c1=0 c2=000 -> 0
//   req1 c0=01 c1=0 c2=001 -> 1 + 4       = 5
//   req2 c0=11 c1=1 c2=101 -> 2 + 2 + 8   = 12
//   req3 c0=11 c1=1 c2=111 -> 2 + 2 + 12  = 16
module tb_counterc_312_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_c0;
  logic [3:0]  req_c1;
  logic [11:0] req_c2;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_id;
  logic [4:0]  out_sum;
  logic [1:0]  stat_sel;
  logic [15:0] stat_cnt;

  int n_chk;
  int n_pass;
  int exp_q[$];
  logic [4:0] exp_sum [4] = '{5'd0, 5'd5, 5'd12, 5'd16};

  counterc_312_arb #(.NREQ(4), .LAT(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_c0   (req_c0),
    .req_c1   (req_c1),
    .req_c2   (req_c2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_id   (out_id),
    .out_sum  (out_sum),
    .stat_sel (stat_sel),
    .stat_cnt (stat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One cycle: drive inputs after the edge, check grant, score any handshake.
  task automatic step(input logic r, input logic [3:0] v, input logic rdy,
                      input logic [3:0] exp_rdy);
    int id;
    @(posedge clk);
    #2;
    rst       = r;
    req_valid = v;
    out_ready = rdy;
    #1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (r) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_id", 32'(out_id), 32'd0);
      check("rst_out_sum", 32'(out_sum), 32'd0);
      exp_q.delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (exp_rdy[i]) exp_q.push_back(i);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          id = exp_q.pop_front();
          check("out_id", 32'(out_id), 32'(id));
          check("out_sum", 32'(out_sum), 32'(exp_sum[id]));
        end
      end
    end
`ifndef COUNTERC_ARB_STATS_EN
    check("stat_cnt_zero", 32'(stat_cnt), 32'd0);
`endif
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst       = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    stat_sel  = '0;
    req_c0    = 8'b11_11_01_00;
    req_c1    = 4'b1100;
    req_c2    = 12'b111_101_001_000;
    repeat (2) @(posedge clk);

    // Reset: grants masked even with everyone valid.
    step(1'b1, 4'b1111, 1'b1, 4'b0000);

    // Single requester 2: grant in cycle t, result at t+2 with sum 12.
    step(1'b0, 4'b0100, 1'b1, 4'b0100);
    step(1'b0, 4'b0000, 1'b1, 4'b0000);
    check("lat_t1_valid", 32'(out_valid), 32'd0);
    step(1'b0, 4'b0000, 1'b1, 4'b0000);
    check("lat_t2_valid", 32'(out_valid), 32'd1);
    check("lat_t2_id", 32'(out_id), 32'd2);
    check("lat_t2_sum", 32'(out_sum), 32'd12);

    // All valid after reset: 0,1,2,3,0,1,2,3 at one grant per cycle.
    step(1'b1, 4'b0000, 1'b1, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 4'b1111, 1'b1, 4'(1 << (k % 4)));
      if (k >= 2) check("tput_valid", 32'(out_valid), 32'd1);
    end

    // Stall 3 cycles with full pipe: output holds grant k=6 (req2, sum 12).
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b1111, 1'b0, 4'b0000);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_id", 32'(out_id), 32'd2);
      check("stall_sum", 32'(out_sum), 32'd12);
    end
    step(1'b0, 4'b1111, 1'b1, 4'b0001);
    repeat (3) step(1'b0, 4'b0000, 1'b1, 4'b0000);
    check("drain_after_stall", 32'(exp_q.size()), 32'd0);

    // Reset with two results in flight; ptr would be 3 without the reset.
    step(1'b0, 4'b0010, 1'b1, 4'b0010);
    step(1'b0, 4'b0100, 1'b1, 4'b0100);
    step(1'b1, 4'b0100, 1'b1, 4'b0000);
    step(1'b0, 4'b1010, 1'b1, 4'b0010);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    step(1'b0, 4'b0000, 1'b1, 4'b0000);
    check("post_rst_valid2", 32'(out_valid), 32'd0);
    step(1'b0, 4'b0000, 1'b1, 4'b0000);
    check("post_rst_result", 32'(out_valid), 32'd1);
    step(1'b0, 4'b0000, 1'b1, 4'b0000);
    check("post_rst_idle", 32'(out_valid), 32'd0);
    check("drain_after_rst", 32'(exp_q.size()), 32'd0);

`ifdef COUNTERC_ARB_STATS_EN
    // Saturation: 70000 grants to requester 1.
    step(1'b1, 4'b0000, 1'b1, 4'b0000);
    @(posedge clk);
    #2;
    rst       = 1'b0;
    req_valid = 4'b0010;
    repeat (70000) @(posedge clk);
    #2;
    req_valid = 4'b0000;
    for (int s = 0; s < 4; s++) begin
      stat_sel = 2'(s);
      repeat (2) @(posedge clk);
      #1;
      check("stat_cnt", 32'(stat_cnt), (s == 1) ? 32'h0000FFFF : 32'd0);
    end
    step(1'b1, 4'b0000, 1'b1, 4'b0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
